// File: rtl/timer_counter_if.sv
// Processor-bus connection between the CPU (master) and the timer_counter (slave).
interface timer_counter_if;
  logic [31:0] PrAddr;
  logic        PrWE;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic [31:0] PrRD;

  modport master (output PrAddr, output PrWE, output PrBE, output PrWD, input PrRD);
  modport slave  (input PrAddr, input PrWE, input PrBE, input PrWD, output PrRD);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot / auto-reload modes
// and an interrupt line for HWInt[0].
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  logic        sel;
  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_en_lane;
  logic        en_next;
  logic        one_shot;
  logic        expire;
  logic        addr_lsb_unused;

  assign sel             = (bus.PrAddr[31:4] == BASE[31:4]);
  assign offset          = bus.PrAddr[3:2];
  assign addr_lsb_unused = ^bus.PrAddr[1:0];
  assign wr_ctrl         = sel && bus.PrWE && (offset == 2'd0);
  assign wr_preset       = sel && bus.PrWE && (offset == 2'd1);
  assign wr_en_lane      = wr_ctrl && bus.PrBE[0];
  // EN as it will be after this edge; a software write here overrides the held value.
  assign en_next         = wr_en_lane ? bus.PrWD[0] : en;
  assign one_shot        = (mode != 2'b01);
  assign expire          = (state == CNT) && en_next && (count <= 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      en          <= 1'b0;
      mode        <= 2'b00;
      im          <= 1'b0;
      preset      <= 32'd0;
      count       <= 32'd0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_en_lane) begin
        mode <= bus.PrWD[2:1];
        im   <= bus.PrWD[3];
      end

      if ((state == INT) && one_shot && !wr_en_lane)
        en <= 1'b0;
      else
        en <= en_next;

      for (int i = 0; i < 4; i++) begin
        if (wr_preset && bus.PrBE[i])
          preset[8*i +: 8] <= bus.PrWD[8*i +: 8];
      end

      // Setting on expiry takes priority over a clearing write on the same edge.
      if (expire && one_shot)
        irq_pending <= 1'b1;
      else if (wr_ctrl || wr_preset)
        irq_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (en_next)
            state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (en_next) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= 32'd0;
              state <= INT;
            end
          end
        end
        INT: begin
          if (one_shot)
            state <= (wr_en_lane && bus.PrWD[0]) ? LOAD : IDLE;
          else
            state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = one_shot ? (irq_pending && im) : (im && (state == INT));

  always_comb begin
    bus.PrRD = 32'd0;
    if (sel) begin
      case (offset)
        2'd0:    bus.PrRD = {28'd0, im, mode, en};
        2'd1:    bus.PrRD = preset;
        2'd2:    bus.PrRD = count;
        default: bus.PrRD = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: one task per feature,
// expected values computed by hand from the register/timing behaviour.
module tb_timer_counter;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] CTRL_A   = BASE;
  localparam logic [31:0] PRESET_A = BASE + 32'h4;
  localparam logic [31:0] COUNT_A  = BASE + 32'h8;
  localparam logic [31:0] RSVD_A   = BASE + 32'hC;
  localparam logic [31:0] OUT_A    = BASE + 32'h10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   compared = 0;
  int   mismatched = 0;

  timer_counter_if bus ();

  timer_counter #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.PrAddr = addr;
    bus.PrWD   = data;
    bus.PrBE   = be;
    bus.PrWE   = 1'b1;
    tick();
    bus.PrWE   = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    bus.PrAddr = addr;
    #1;
    data = bus.PrRD;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addrs [4];
    addrs = '{CTRL_A, PRESET_A, COUNT_A, RSVD_A};
    tick();
    for (int i = 0; i < 4; i++) begin
      read_reg(addrs[i], rd);
      compared++;
      if (rd !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_read[%0d]: got %h expected %h", i, rd, 32'd0);
      end
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    do_reset();
    write_reg(PRESET_A, 32'd5, 4'hF);
    write_reg(CTRL_A, 32'h9, 4'hF);
    for (int j = 1; j <= 6; j++) begin
      tick();
      read_reg(COUNT_A, rd);
      compared++;
      if (rd !== 32'(6 - j)) begin
        mismatched++;
        $display("[TB] FAIL oneshot_count[k+%0d]: got %0d expected %0d", j, rd, 6 - j);
      end
      compared++;
      if (irq !== (j == 6)) begin
        mismatched++;
        $display("[TB] FAIL oneshot_irq[k+%0d]: got %b expected %b", j, irq, (j == 6));
      end
    end
    tick();
    read_reg(CTRL_A, rd);
    compared++;
    if (rd !== 32'h8) begin
      mismatched++;
      $display("[TB] FAIL oneshot_ctrl_en_cleared: got %h expected %h", rd, 32'h8);
    end
    repeat (3) tick();
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL oneshot_irq_held: got %b expected 1", irq);
    end
    write_reg(CTRL_A, 32'h8, 4'hF);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL oneshot_irq_cleared: got %b expected 0", irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] rd;
    logic [31:0] seq [5];
    int pulses;
    seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    pulses = 0;
    do_reset();
    write_reg(PRESET_A, 32'd3, 4'hF);
    write_reg(CTRL_A, 32'hB, 4'hF);
    for (int t = 1; t <= 10; t++) begin
      tick();
      read_reg(COUNT_A, rd);
      compared++;
      if (rd !== seq[(t - 1) % 5]) begin
        mismatched++;
        $display("[TB] FAIL auto_count[k+%0d]: got %0d expected %0d", t, rd, seq[(t - 1) % 5]);
      end
      compared++;
      if (irq !== ((t - 1) % 5 == 3)) begin
        mismatched++;
        $display("[TB] FAIL auto_irq[k+%0d]: got %b expected %b", t, irq, ((t - 1) % 5 == 3));
      end
      if (irq === 1'b1) pulses++;
    end
    compared++;
    if (pulses !== 2) begin
      mismatched++;
      $display("[TB] FAIL auto_pulse_count: got %0d expected 2", pulses);
    end
    write_reg(CTRL_A, 32'h3, 4'hF);
    for (int t = 11; t <= 21; t++) begin
      if (t > 11) tick();
      read_reg(COUNT_A, rd);
      compared++;
      if (rd !== seq[(t - 1) % 5]) begin
        mismatched++;
        $display("[TB] FAIL auto_noim_count[k+%0d]: got %0d expected %0d", t, rd, seq[(t - 1) % 5]);
      end
      compared++;
      if (irq !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL auto_noim_irq[k+%0d]: got %b expected 0", t, irq);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    do_reset();
    write_reg(PRESET_A, 32'h1122_3344, 4'hF);
    write_reg(PRESET_A, 32'hAABB_CCDD, 4'b0011);
    read_reg(PRESET_A, rd);
    compared++;
    if (rd !== 32'h1122_CCDD) begin
      mismatched++;
      $display("[TB] FAIL lane_merge: got %h expected %h", rd, 32'h1122_CCDD);
    end
    write_reg(COUNT_A, 32'hFFFF_FFFF, 4'hF);
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL count_readonly: got %h expected %h", rd, 32'd0);
    end
    write_reg(OUT_A, 32'h5555_5555, 4'hF);
    write_reg(RSVD_A, 32'h1234_5678, 4'hF);
    read_reg(OUT_A, rd);
    compared++;
    if (rd !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL outside_read: got %h expected %h", rd, 32'd0);
    end
    read_reg(RSVD_A, rd);
    compared++;
    if (rd !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reserved_read: got %h expected %h", rd, 32'd0);
    end
    read_reg(PRESET_A, rd);
    compared++;
    if (rd !== 32'h1122_CCDD) begin
      mismatched++;
      $display("[TB] FAIL preset_untouched: got %h expected %h", rd, 32'h1122_CCDD);
    end
    write_reg(CTRL_A, 32'hFFFF_FF06, 4'hF);
    read_reg(CTRL_A, rd);
    compared++;
    if (rd !== 32'h6) begin
      mismatched++;
      $display("[TB] FAIL ctrl_upper_zero: got %h expected %h", rd, 32'h6);
    end
    write_reg(CTRL_A, 32'h0000_0001, 4'b0010);
    read_reg(CTRL_A, rd);
    compared++;
    if (rd !== 32'h6) begin
      mismatched++;
      $display("[TB] FAIL ctrl_lane_masked: got %h expected %h", rd, 32'h6);
    end
  endtask

  task automatic test_pause();
    logic [31:0] rd;
    do_reset();
    write_reg(PRESET_A, 32'd10, 4'hF);
    write_reg(CTRL_A, 32'h1, 4'hF);
    repeat (4) tick();
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd7) begin
      mismatched++;
      $display("[TB] FAIL pause_start: got %0d expected 7", rd);
    end
    write_reg(CTRL_A, 32'h0, 4'hF);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) tick();
      read_reg(COUNT_A, rd);
      compared++;
      if (rd !== 32'd7) begin
        mismatched++;
        $display("[TB] FAIL pause_hold[%0d]: got %0d expected 7", i, rd);
      end
    end
    write_reg(PRESET_A, 32'd100, 4'hF);
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd7) begin
      mismatched++;
      $display("[TB] FAIL pause_preset_write: got %0d expected 7", rd);
    end
    write_reg(CTRL_A, 32'h1, 4'hF);
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd6) begin
      mismatched++;
      $display("[TB] FAIL resume_first: got %0d expected 6", rd);
    end
    tick();
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd5) begin
      mismatched++;
      $display("[TB] FAIL resume_second: got %0d expected 5", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    do_reset();
    write_reg(PRESET_A, 32'd2, 4'hF);
    write_reg(CTRL_A, 32'h9, 4'hF);
    tick();
    tick();
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_count_before_int: got %0d expected 1", rd);
    end
    write_reg(PRESET_A, 32'd2, 4'hF);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_set_beats_clear: got %b expected 1", irq);
    end
    write_reg(CTRL_A, 32'h9, 4'hF);
    read_reg(CTRL_A, rd);
    compared++;
    if (rd !== 32'h9) begin
      mismatched++;
      $display("[TB] FAIL b2b_sw_en_wins: got %h expected %h", rd, 32'h9);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_irq_cleared: got %b expected 0", irq);
    end
    tick();
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL b2b_reload: got %0d expected 2", rd);
    end
  endtask

  task automatic test_preset_zero();
    do_reset();
    write_reg(PRESET_A, 32'd0, 4'hF);
    write_reg(CTRL_A, 32'h9, 4'hF);
    tick();
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_early_irq: got %b expected 0", irq);
    end
    tick();
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL zero_expire: got %b expected 1", irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic [31:0] addrs [3];
    addrs = '{CTRL_A, PRESET_A, COUNT_A};
    do_reset();
    write_reg(PRESET_A, 32'd1, 4'hF);
    write_reg(CTRL_A, 32'h9, 4'hF);
    tick();
    tick();
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL areset_irq_pre: got %b expected 1", irq);
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL areset_irq_drop: got %b expected 0", irq);
    end
    reset = 1'b0;
    tick();
    write_reg(PRESET_A, 32'd20, 4'hF);
    write_reg(CTRL_A, 32'h9, 4'hF);
    repeat (5) tick();
    read_reg(COUNT_A, rd);
    compared++;
    if (rd !== 32'd16) begin
      mismatched++;
      $display("[TB] FAIL areset_midcount_pre: got %0d expected 16", rd);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_reg(addrs[i], rd);
      compared++;
      if (rd !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL areset_clear[%0d]: got %h expected %h", i, rd, 32'd0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      read_reg(COUNT_A, rd);
      compared++;
      if (rd !== 32'd0) begin
        mismatched++;
        $display("[TB] FAIL areset_idle_count[%0d]: got %0d expected 0", i, rd);
      end
      read_reg(CTRL_A, rd);
      compared++;
      if (rd !== 32'd0 || irq !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL areset_idle_ctrl[%0d]: got ctrl %h irq %b expected 0/0", i, rd, irq);
      end
    end
  endtask

  initial begin
    bus.PrAddr = 32'd0;
    bus.PrWE   = 1'b0;
    bus.PrBE   = 4'h0;
    bus.PrWD   = 32'd0;
    $display("[TB] starting timer_counter bench");
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byte_lanes();
    test_pause();
    test_back_to_back();
    test_preset_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter that responds to the CPU's processor bus (PrAddr/PrWE/PrBE/PrWD/PrRD) and drives one HWInt line. The CPU is the bus initiator and this block is the responder. Software writes a preset and a control word, and the block counts down at the core clock. When the count expires it raises an interrupt, in either one-shot or auto-reload mode. One instance sits beside the data memory in the system bridge. Its irq output connects to HWInt[0].

## Interface
- BASE, 32'h0000_7F00: word-aligned base address; the block decodes a 16-byte window starting at BASE.
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- PrAddr  in  32  bus byte address; bits [1:0] are ignored.
- PrWE  in  1  write strobe for the current cycle.
- PrBE  in  4  byte-lane enables for writes; bit i covers PrWD[8i+7:8i].
- PrWD  in  32  write data.
- PrRD  out  32  read data; combinational from PrAddr and the current register contents.
- irq  out  1  interrupt request to HWInt[0].

## Operation
- Register map, selected when PrAddr[31:4]==BASE[31:4]:
  - +0x0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM. Other bits read 0.
  - +0x4 PRESET: 32-bit, read/write.
  - +0x8 COUNT: 32-bit, read-only.
  - +0xC: reads 0.
- Writes:
  - A write to CTRL or PRESET takes effect at the clock edge while PrWE=1, merged per PrBE lane.
  - Writes to COUNT, to +0xC, or outside the window are ignored.
  - Unselected addresses read 0.
- MODE 00 is one-shot. MODE 01 is auto-reload. MODE 1x behaves as 00.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD. COUNT holds its value.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: pause. COUNT holds and the state stays CNT.
  - CNT, EN=1, COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1, COUNT<=1: COUNT <= 0; go to INT.
  - INT, one-shot: EN <= 0; go to IDLE.
  - INT, auto-reload: go to LOAD.
- Interrupt:
  - irq_pending is set on the edge entering INT in one-shot mode.
  - irq_pending is cleared by any write to CTRL or PRESET.
  - One-shot: irq = irq_pending & IM, held high until software clears it.
  - Auto-reload: irq = IM while state==INT, a one-cycle pulse.
- Simultaneous events:
  - A CTRL write on the same edge as the INT->IDLE EN clear: the software-written EN value wins.
  - A write that clears irq_pending on the same edge that sets it: the set wins.
  - A PRESET write during CNT does not disturb COUNT; it applies at the next LOAD.
- PRESET=0: LOAD loads 0, and the next CNT edge enters INT, same as PRESET=1.
- COUNT never wraps below 0.

## Timing
- Reset (asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state IDLE. irq=0 immediately; PrRD=0 for every address in the window.
- Writes are visible on PrRD the cycle after the write edge. Reads have zero latency.
- EN written to 1 at edge k, with PRESET=N≥1:
  - LOAD is the state after edge k.
  - COUNT=N after edge k+1.
  - COUNT=N-j after edge k+1+j.
  - COUNT=0 and state INT after edge k+1+N.
- One-shot: irq rises after edge k+1+N and EN reads 0 after edge k+2+N.
- Auto-reload period is N+2 cycles: LOAD, N CNT cycles, INT.
- Reset asserted mid-count aborts immediately. After deassertion the block is idle until EN is written again.

## Test plan
- One-shot expiry: reset, write PRESET=5, then CTRL=0x9 at edge k.
  - COUNT reads 5,4,3,2,1,0 after edges k+1..k+6.
  - irq=1 from after edge k+6 and stays high.
  - CTRL reads 0x8 after edge k+7.
  - Writing CTRL=0x8 drops irq.
- Auto-reload: PRESET=3, CTRL=0xB.
  - irq pulses exactly one cycle every 5 cycles.
  - COUNT sequence is 3,2,1,0,0(LOAD),3,...
  - With IM=0, irq stays 0 and counting is unchanged.
- Byte lanes / decode:
  - Write PRESET with PrBE=4'b0011 and PrWD=0xAABBCCDD over 0x11223344; it reads 0x1122CCDD.
  - A write to BASE+8 leaves COUNT unchanged.
  - A read of BASE+0x10 returns 0.
- Pause/resume: during counting at COUNT=7, write CTRL EN=0.
  - COUNT holds 7 for 10 cycles.
  - Re-enable; COUNT resumes at 6 on the next edge.
  - A PRESET write while paused does not change COUNT.
- Simultaneity:
  - A CTRL write of EN=1 on the one-shot INT edge keeps EN=1 and re-enters LOAD.
  - PRESET=0 expires 2 cycles after enable.
- Async reset: assert reset between clock edges mid-count.
  - irq, COUNT and CTRL read 0 before the next edge.
  - After release there is no activity until EN is set.
